retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
- Sits between the CPU's write-back (retire) output and the 7-segment hex encoders on the FPGA board top.
- The CPU retires PCs on the fast core clock. The display refreshes far slower.
- This block captures every retired PC into a small FIFO and releases one entry per display tick into a held display register.
- It counts retirements that had to be dropped, so the human-visible PC sequence is ordered and lossless up to DEPTH.

Parameters:
- XLEN, 64, width of a retired PC; the display consumes bits [31:0].
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  core clock, same clock as the CPU.
- rstn  in  1  asynchronous active-low reset.
- wb_valid  in  1  one-cycle strobe: a PC retired this cycle.
- wb_pc  in  XLEN  retired PC, valid when wb_valid=1.
- dsp_tick  in  1  one-cycle pulse from the refresh divider requesting the next PC.
- freeze  in  1  level: hold the display and stop popping; pushes continue.
- disp_pc  out  XLEN  PC currently shown.
- disp_valid  out  1  disp_pc holds a real popped PC.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  DROP_W  saturating count of dropped retirements.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (rstn=0, asynchronous assert, synchronous-to-clk deassert handled externally) sets:
  - disp_pc=0, disp_valid=0, level=0, drop_cnt=0, overflow=0;
  - read and write pointers to 0.
  - Mid-operation reset discards all FIFO contents immediately.
- Push: wb_valid=1 and (not full, or pop this cycle) writes wb_pc at the write pointer; the write pointer increments and wraps modulo DEPTH.
- Pop condition: dsp_tick=1 and freeze=0 and level>0.
  - On a pop, the head entry is loaded into disp_pc at the next clk edge and disp_valid is set to 1.
  - The read pointer increments and wraps.
  - Latency: a push at edge N followed by a tick at edge N+1 gives disp_pc = that PC after edge N+1. There is no fall-through, so the earliest visibility is one cycle after the push.
- Empty + tick: no pop; disp_pc and disp_valid hold their values (the last PC stays shown).
- Full + wb_valid, no pop:
  - the new PC is dropped and the FIFO is unchanged;
  - drop_cnt increments, saturating at 2^DROP_W-1;
  - overflow is set to 1 and stays set until reset.
- Full + wb_valid + pop in the same cycle: both happen, nothing is dropped, level stays at DEPTH.
- Empty + wb_valid + tick in the same cycle: push only. The pop is not taken because level was 0; no bypass.
- freeze=1: ticks are ignored and disp_pc is held. The FIFO keeps filling and then drops per the full rule.
- level is updated as follows: +1 on push-only, -1 on pop-only, unchanged on both or neither. It ranges 0..DEPTH inclusive; use the extra pointer bit or an explicit counter.
- wb_pc is ignored when wb_valid=0, and dsp_tick is ignored while rstn=0.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package trace_pkg holds:
  - the XLEN default, tied to the codebase's immediate/PC width macro;
  - the pointer-width function/constant, clog2 of DEPTH;
  - the drop-counter saturation constant.
- One sub-module, trace_fifo: a synchronous circular buffer with push, pop, full, empty and level.
- Drop counting, the overflow flag, the freeze/tick gating and the display register live in retire_trace_buffer.

Test Plan:
- Reset check: hold rstn=0 with wb_valid toggling → all outputs 0. Release, push 0x80000000, tick next cycle → disp_pc=0x80000000, disp_valid=1, level=0.
- Ordering: push 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, then 3 spaced ticks → disp_pc steps through those values in order, level goes 3→2→1→0. A 4th tick leaves disp_pc=0x80000008.
- Overflow: push 10 PCs 0x100..0x124 (step 4) with no ticks → level=8, drop_cnt=2, overflow=1. Then 8 ticks display 0x100..0x11C, and 0x120/0x124 never appear.
- Full simultaneous push/pop: fill to 8, then wb_valid plus tick in the same cycle → disp_pc=head value, level stays 8, drop_cnt is unchanged.
- Freeze: disp_pc=0x200 shown, freeze=1, push 0x204, issue 3 ticks → disp_pc stays 0x200 and level=1. Set freeze=0 and tick → disp_pc=0x204.
- Saturation and async reset: with DROP_W=8, cause 300 drops → drop_cnt=255. Assert rstn low mid-cycle → all outputs clear before the next clk edge.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared widths and constants for the retire trace buffer and its FIFO.
`ifndef CORE_PC_W
`define CORE_PC_W 64
`endif

package trace_pkg;

    localparam int XLEN_DEFAULT   = `CORE_PC_W;
    localparam int DEPTH_DEFAULT  = 8;
    localparam int DROP_W_DEFAULT = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // All-ones value of a w-bit counter; valid for w up to 63.
    function automatic logic [63:0] drop_sat(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous circular buffer; head is presented combinationally on pop_data_o.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int W     = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired PCs into a FIFO and releases one per display tick into a held register.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DROP_W = DROP_W_DEFAULT,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wb_valid,
    input  logic [XLEN-1:0]   wb_pc,
    input  logic              dsp_tick,
    input  logic              freeze,
    output logic [XLEN-1:0]   disp_pc,
    output logic              disp_valid,
    output logic [LW-1:0]     level,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);

    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(drop_sat(DROP_W));

    logic            fifo_full, fifo_empty;
    logic [XLEN-1:0] head_pc;
    logic            pop, push, drop;

    logic [XLEN-1:0]   disp_pc_q,    disp_pc_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DROP_W-1:0] drop_cnt_q,   drop_cnt_d;
    logic              overflow_q,   overflow_d;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop  = dsp_tick & ~freeze & ~fifo_empty;
    assign push = wb_valid & (~fifo_full | pop);
    assign drop = wb_valid & fifo_full & ~pop;

    trace_fifo #(
        .W     (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (wb_pc),
        .pop_i       (pop),
        .pop_data_o  (head_pc),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    always_comb begin
        disp_pc_d    = disp_pc_q;
        disp_valid_d = disp_valid_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        if (pop) begin
            disp_pc_d    = head_pc;
            disp_valid_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_pc_q    <= '0;
            disp_valid_q <= 1'b0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            disp_pc_q    <= disp_pc_d;
            disp_valid_q <= disp_valid_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign disp_pc    = disp_pc_q;
    assign disp_valid = disp_valid_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed plan plus random traffic against a queue-based model.
module tb_retire_trace_buffer;

    localparam int XLEN   = 64;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int SAT    = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wb_valid = 1'b0;
    logic [XLEN-1:0]   wb_pc = '0;
    logic              dsp_tick = 1'b0;
    logic              freeze = 1'b0;
    logic [XLEN-1:0]   disp_pc;
    logic              disp_valid;
    logic [LW-1:0]     level;
    logic [DROP_W-1:0] drop_cnt;
    logic              overflow;

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .dsp_tick   (dsp_tick),
        .freeze     (freeze),
        .disp_pc    (disp_pc),
        .disp_valid (disp_valid),
        .level      (level),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending PCs plus the displayed value and drop bookkeeping.
    logic [XLEN-1:0] m_q[$];
    logic [XLEN-1:0] m_disp;
    logic            m_dv;
    int              m_drop;
    logic            m_ov;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_disp = '0;
        m_dv   = 1'b0;
        m_drop = 0;
        m_ov   = 1'b0;
    endfunction

    function automatic void m_update();
        bit do_pop;
        if (!rstn) begin
            m_reset();
            return;
        end
        do_pop = dsp_tick && !freeze && (m_q.size() > 0);
        if (do_pop) begin
            m_disp = m_q.pop_front();
            m_dv   = 1'b1;
        end
        if (wb_valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(wb_pc);
            else begin
                if (m_drop < SAT) m_drop++;
                m_ov = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("disp_pc",    disp_pc,    m_disp);
            chk("disp_valid", {63'd0, disp_valid}, {63'd0, m_dv});
            chk("level",      64'(level),    64'(m_q.size()));
            chk("drop_cnt",   64'(drop_cnt), 64'(m_drop));
            chk("overflow",   {63'd0, overflow}, {63'd0, m_ov});
        end
    end

    // Inputs change 1 time unit after the falling edge, well clear of both edges.
    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic tick, input logic frz);
        #1;
        wb_valid = v;
        wb_pc    = pc;
        dsp_tick = tick;
        freeze   = frz;
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic set_rst(input logic val);
        #1;
        rstn = val;
        if (!val) m_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        m_reset();
        cmp_en = 1'b1;

        // Reset held with wb_valid toggling
        for (int i = 0; i < 4; i++) drive(i[0], 64'h1000 + 64'(i), 1'b1, 1'b0);
        chk("rst_disp_pc", disp_pc, 64'h0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        set_rst(1'b1);
        drive(1'b1, 64'h8000_0000, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("first_pc", disp_pc, 64'h8000_0000);
        chk("first_valid", {63'd0, disp_valid}, 64'd1);
        chk("first_level", 64'(level), 64'd0);

        // Ordering with spaced ticks
        for (int i = 0; i < 3; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
        chk("ord_level0", 64'(level), 64'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("ord_pc", disp_pc, 64'h8000_0000 + 64'(4 * i));
            chk("ord_level", 64'(level), 64'(2 - i));
            idle(2);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("ord_empty_tick", disp_pc, 64'h8000_0008);

        // Overflow: ten pushes into eight slots
        for (int i = 0; i < 10; i++) drive(1'b1, 64'h100 + 64'(4 * i), 1'b0, 1'b0);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("ovf_drain", disp_pc, 64'h100 + 64'(4 * i));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("ovf_no_dropped", disp_pc, 64'h11C);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) drive(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 64'h400, 1'b1, 1'b0);
        chk("fullpp_pc", disp_pc, 64'h300);
        chk("fullpp_level", 64'(level), 64'd8);
        chk("fullpp_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
        chk("fullpp_last", disp_pc, 64'h400);

        // Freeze holds the display while pushes continue
        drive(1'b1, 64'h200, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("frz_shown", disp_pc, 64'h200);
        drive(1'b1, 64'h204, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b1);
        chk("frz_hold", disp_pc, 64'h200);
        chk("frz_level", 64'(level), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("frz_release", disp_pc, 64'h204);

        // Empty FIFO: push and tick together is push only
        drive(1'b1, 64'h500, 1'b1, 1'b0);
        chk("empty_pt_pc", disp_pc, 64'h204);
        chk("empty_pt_level", 64'(level), 64'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                set_rst(1'b0);
                drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
                set_rst(1'b1);
            end
            drive($urandom_range(0, 99) < 55, {$urandom, $urandom},
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15);
        end

        // Saturation of the drop counter
        set_rst(1'b0);
        idle(1);
        set_rst(1'b1);
        for (int i = 0; i < 308; i++) drive(1'b1, 64'h600 + 64'(i), 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        chk("sat_level", 64'(level), 64'd8);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("sat_head", disp_pc, 64'h600);

        // Asynchronous reset mid-cycle clears outputs before the next rising edge
        #2;
        rstn = 1'b0;
        m_reset();
        #1;
        chk("async_disp_pc", disp_pc, 64'h0);
        chk("async_valid", {63'd0, disp_valid}, 64'd0);
        chk("async_level", 64'(level), 64'd0);
        chk("async_drop", 64'(drop_cnt), 64'd0);
        chk("async_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        set_rst(1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_empty", 64'(level), 64'd0);
        idle(2);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
